// File: rtl/fphub_pkg.sv
// Shared FPHUB format definitions for the square and square-root units.
// Default field widths, bias, field helpers and the common state encoding.
package fphub_pkg;

    localparam int FPHUB_M = 23;
    localparam int FPHUB_E = 8;

    localparam logic [FPHUB_E-1:0] FPHUB_EXP_ZERO = '0;
    localparam logic [FPHUB_E-1:0] FPHUB_EXP_ONES = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        NORM = 2'd2
    } fphub_state_e;

    function automatic int fphub_bias(input int e);
        return (1 << (e - 1)) - 1;
    endfunction

    function automatic logic [FPHUB_E-1:0] fphub_exp(input logic [FPHUB_M+FPHUB_E:0] v);
        return v[FPHUB_M+FPHUB_E-1:FPHUB_M];
    endfunction

    function automatic logic [FPHUB_M-1:0] fphub_mant(input logic [FPHUB_M+FPHUB_E:0] v);
        return v[FPHUB_M-1:0];
    endfunction

endpackage

// File: rtl/fphub_sq_datapath.sv
// Radix-2 shift-add squaring accumulator with iteration counter.
// Only the product bits that survive normalization are exported.
module fphub_sq_datapath #(
    parameter int M = 23
) (
    input  logic         clk,
    input  logic         rst_l,
    input  logic         load,
    input  logic         step,
    input  logic [M+1:0] mx,
    output logic [M+1:0] p_hi,
    output logic         done
);

    localparam int PW = 2 * M + 4;
    localparam int CW = $clog2(M + 2);
    localparam logic [CW-1:0] LAST = CW'(M + 1);

    logic [PW-1:0]  mcand_q;
    logic [M+1:0]   mplier_q;
    logic [PW-1:0]  p_q;
    logic [CW-1:0]  cnt_q;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            p_q      <= '0;
            cnt_q    <= '0;
        end else if (load) begin
            mcand_q  <= {{(PW-M-2){1'b0}}, mx};
            mplier_q <= mx;
            p_q      <= '0;
            cnt_q    <= '0;
        end else if (step) begin
            if (mplier_q[0]) begin
                p_q <= p_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
        end
    end

    // Product is in [1,4) with 2M+2 fraction bits; bits below PW-M-2 are truncated.
    assign p_hi = p_q[PW-1 -: M+2];
    assign done = (cnt_q == LAST);

endmodule

// File: rtl/fphub_square.sv
// Iterative FPHUB squaring unit: x*x with HUB round-to-nearest by truncation.
//   state | meaning
//   IDLE  | waiting for start; decodes special operands
//   ITER  | one shift-add step per cycle, M+2 steps
//   NORM  | normalize, form exponent, publish res and pulse finish
module fphub_square
    import fphub_pkg::*;
#(
    parameter int M = FPHUB_M,
    parameter int E = FPHUB_E
) (
    input  logic         clk,
    input  logic         rst_l,
    input  logic         start,
    input  logic [M+E:0] x,
    output logic [M+E:0] res,
    output logic         finish,
    output logic         computing
);

    localparam int T = M + E;
    localparam logic [E+1:0] BIAS_W = (E+2)'(fphub_bias(E));
    localparam logic [E+1:0] INF_E  = {2'b00, {E{1'b1}}};

    fphub_state_e state_q, state_d;

    logic [E-1:0] e_x_q, e_x_d;
    logic         special_q, special_d;
    logic [T:0]   spec_res_q, spec_res_d;
    logic [T:0]   res_q, res_d;
    logic         finish_q, finish_d;
    logic         computing_q, computing_d;

    logic         load, step, done;
    logic [M+1:0] p_hi;

    logic [E-1:0] exp_x;
    logic [M-1:0] man_x;
    logic         is_special;
    logic [T:0]   spec_val;

    assign exp_x      = x[T-1:M];
    assign man_x      = x[M-1:0];
    assign is_special = (exp_x == '0) || (&exp_x);

    always_comb begin
        spec_val = '0;
        if (&exp_x) begin
            if (man_x == '0) begin
                spec_val = {1'b0, {E{1'b1}}, {M{1'b0}}};
            end else begin
                spec_val = x & {1'b0, {T{1'b1}}};
            end
        end
    end

    fphub_sq_datapath #(.M(M)) u_dp (
        .clk   (clk),
        .rst_l (rst_l),
        .load  (load),
        .step  (step),
        .mx    ({1'b1, man_x, 1'b1}),
        .p_hi  (p_hi),
        .done  (done)
    );

    logic         n_shift;
    logic [M-1:0] mant;
    logic [E+1:0] e_r;
    logic [T:0]   norm_res;

    assign n_shift = p_hi[M+1];
    assign mant    = n_shift ? p_hi[M -: M] : p_hi[M-1 -: M];
    assign e_r     = {1'b0, e_x_q, 1'b0} - BIAS_W + {{(E+1){1'b0}}, n_shift};

    always_comb begin
        if ($signed(e_r) >= $signed(INF_E)) begin
            norm_res = {1'b0, {E{1'b1}}, {M{1'b0}}};
        end else if (e_r[E+1] || (e_r == '0)) begin
            norm_res = '0;
        end else begin
            norm_res = {1'b0, e_r[E-1:0], mant};
        end
    end

    always_comb begin
        state_d     = state_q;
        e_x_d       = e_x_q;
        special_d   = special_q;
        spec_res_d  = spec_res_q;
        res_d       = res_q;
        finish_d    = 1'b0;
        computing_d = computing_q;
        load        = 1'b0;
        step        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    e_x_d      = exp_x;
                    special_d  = is_special;
                    spec_res_d = spec_val;
                    if (is_special) begin
                        state_d = NORM;
                    end else begin
                        load    = 1'b1;
                        state_d = ITER;
                    end
                end
            end
            ITER: begin
                step        = 1'b1;
                computing_d = 1'b1;
                if (done) begin
                    state_d = NORM;
                end
            end
            NORM: begin
                computing_d = 1'b0;
                finish_d    = 1'b1;
                res_d       = special_q ? spec_res_q : norm_res;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q     <= IDLE;
            e_x_q       <= '0;
            special_q   <= 1'b0;
            spec_res_q  <= '0;
            res_q       <= '0;
            finish_q    <= 1'b0;
            computing_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            e_x_q       <= e_x_d;
            special_q   <= special_d;
            spec_res_q  <= spec_res_d;
            res_q       <= res_d;
            finish_q    <= finish_d;
            computing_q <= computing_d;
        end
    end

    assign res       = res_q;
    assign finish    = finish_q;
    assign computing = computing_q;

endmodule

// File: tb/tb_fphub_square.sv
// Bench for fphub_square: behavioural reference model checked every cycle,
// plus literal cases for latency, specials, busy-start, back-to-back and reset.
module tb_fphub_square;
    import fphub_pkg::*;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        start = 1'b0;
    logic [31:0] x = '0;
    logic [31:0] res;
    logic        finish;
    logic        computing;

    int checks = 0;
    int errors = 0;

    fphub_square dut (
        .clk       (clk),
        .rst_l     (rst_l),
        .start     (start),
        .x         (x),
        .res       (res),
        .finish    (finish),
        .computing (computing)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] sq_model(input logic [31:0] v);
        logic [7:0]      ex;
        logic [22:0]     mn;
        longint unsigned mx, p;
        int              er;
        ex = fphub_exp(v);
        mn = fphub_mant(v);
        if (ex == 8'd0) return 32'd0;
        if (ex == FPHUB_EXP_ONES) return (mn == 23'd0) ? 32'h7F80_0000 : {1'b0, v[30:0]};
        mx = (64'd1 << 24) | (64'(mn) << 1) | 64'd1;
        p  = mx * mx;
        er = 2 * int'(ex) - 127;
        if (p >= (64'd1 << 49)) begin
            p  = p >> 1;
            er = er + 1;
        end
        if (er >= 255) return 32'h7F80_0000;
        if (er <= 0) return 32'd0;
        return {1'b0, 8'(er), 23'((p >> 25) & 64'h7F_FFFF)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference model: tracks acceptance, completion edge and expected outputs.
    int          ecnt = 0;
    int          fin_edge = 0;
    int          acc_edge = 0;
    bit          busy = 1'b0;
    bit          spec_op = 1'b0;
    logic [31:0] pend = '0;
    logic [31:0] res_exp = '0;
    logic        fin_exp = 1'b0;
    logic        comp_exp = 1'b0;

    always @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            busy     = 1'b0;
            res_exp  = '0;
            fin_exp  = 1'b0;
            comp_exp = 1'b0;
        end else begin
            bit accept;
            ecnt    = ecnt + 1;
            accept  = start && !busy;
            fin_exp = 1'b0;
            if (busy && ecnt == fin_edge) begin
                busy    = 1'b0;
                fin_exp = 1'b1;
                res_exp = pend;
            end
            if (accept) begin
                busy     = 1'b1;
                pend     = sq_model(x);
                spec_op  = (fphub_exp(x) == FPHUB_EXP_ZERO) || (fphub_exp(x) == FPHUB_EXP_ONES);
                acc_edge = ecnt;
                fin_edge = ecnt + (spec_op ? 1 : 26);
            end
            comp_exp = busy && !spec_op && (ecnt > acc_edge);
        end
    end

    always @(negedge clk) begin
        chk("res", res, res_exp);
        chk("finish", 32'(finish), 32'(fin_exp));
        chk("computing", 32'(computing), 32'(comp_exp));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] v);
        start = 1'b1;
        x     = v;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_fin(output int lat, output int comp);
        lat  = 0;
        comp = 0;
        while (lat < 40) begin
            tick();
            lat++;
            if (computing) comp++;
            if (finish) break;
        end
        checks++;
        if (!finish) begin
            errors++;
            $display("FAIL finish_timeout: got no finish expected finish within 40 cycles");
        end
    endtask

    task automatic run_lit(input string name, input logic [31:0] v, input logic [31:0] expv,
                           input int exp_lat, input int exp_comp);
        int lat, comp;
        issue(v);
        wait_fin(lat, comp);
        chk({name, "_res"}, res, expv);
        chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({name, "_comp"}, 32'(comp), 32'(exp_comp));
        tick();
        chk({name, "_fin_width"}, 32'(finish), 32'd0);
    endtask

    function automatic logic [31:0] rand_x();
        logic [31:0] v;
        int sel;
        v   = $urandom;
        sel = $urandom_range(0, 9);
        if (sel == 0) v[30:23] = 8'h00;
        else if (sel == 1) v[30:23] = 8'hFF;
        else if (sel == 2) v[22:0] = (($urandom_range(0, 1) == 0) ? 23'd0 : v[22:0]);
        else if (sel < 7) v[30:23] = 8'($urandom_range(70, 190));
        if (sel == 1 && $urandom_range(0, 1) == 0) v[22:0] = 23'd0;
        return v;
    endfunction

    initial begin
        int lat, comp, fin_cnt;

        chk("model_one", sq_model(32'h3F80_0000), 32'h3F80_0001);
        chk("model_m3", sq_model(32'hC040_0000), 32'h4110_0000);
        chk("model_ovf", sq_model(32'h7F00_0000), 32'h7F80_0000);
        chk("model_two", sq_model(32'h4000_0000), 32'h4080_0001);

        repeat (3) tick();
        chk("rst_res", res, 32'd0);
        chk("rst_finish", 32'(finish), 32'd0);
        chk("rst_computing", 32'(computing), 32'd0);
        rst_l = 1'b1;
        tick();

        run_lit("one", 32'h3F80_0000, 32'h3F80_0001, 26, 25);
        run_lit("neg3", 32'hC040_0000, 32'h4110_0000, 26, 25);
        run_lit("ovf", 32'h7F00_0000, 32'h7F80_0000, 26, 25);
        run_lit("unf", 32'h1F00_0000, 32'h0000_0000, 26, 25);
        run_lit("zero", 32'h0000_0000, 32'h0000_0000, 1, 0);
        run_lit("ninf", 32'hFF80_0000, 32'h7F80_0000, 1, 0);
        run_lit("nan", 32'hFFC0_0001, 32'h7FC0_0001, 1, 0);

        issue(32'h3F80_0000);
        repeat (4) tick();
        issue(32'h4000_0000);
        wait_fin(lat, comp);
        chk("busy_start_res", res, 32'h3F80_0001);
        chk("busy_start_lat", 32'(lat), 32'd21);
        tick();

        issue(32'h3F80_0000);
        wait_fin(lat, comp);
        chk("b2b_first_res", res, 32'h3F80_0001);
        issue(32'h4040_0000);
        wait_fin(lat, comp);
        chk("b2b_second_res", res, 32'h4110_0000);
        chk("b2b_second_lat", 32'(lat), 32'd26);
        tick();

        issue(32'h3F80_0000);
        repeat (10) tick();
        rst_l = 1'b0;
        #1;
        chk("midrst_res", res, 32'd0);
        chk("midrst_finish", 32'(finish), 32'd0);
        chk("midrst_computing", 32'(computing), 32'd0);
        tick();
        rst_l = 1'b1;
        fin_cnt = 0;
        repeat (30) begin
            tick();
            if (finish) fin_cnt++;
        end
        chk("midrst_no_finish", 32'(fin_cnt), 32'd0);
        run_lit("two", 32'h4000_0000, 32'h4080_0001, 26, 25);

        repeat (3000) begin
            start = ($urandom_range(0, 3) == 0);
            x     = rand_x();
            tick();
        end
        start = 1'b0;
        repeat (30) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
